// File: rtl/div_sequencer.sv
// Multi-cycle sequencer around a combinational divider: registers operands, waits
// SETTLE_CYCLES edges, captures remainder/quotient into HI/LO; handles /0 and bus loads.
module div_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        ready,
  output logic        busy,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [64:0] div_c,
  output logic        done,
  output logic        div_by_zero,
  input  logic [31:0] bus_in,
  input  logic        hi_ld,
  input  logic        lo_ld,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;

  // Divider overflow bit carries no architectural meaning here.
  logic unused_div_c_msb;
  assign unused_div_c_msb = div_c[64];

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      cnt         <= 4'd0;
      div_a       <= 32'd0;
      div_b       <= 32'd0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= capture;
      if (accept) begin
        div_a       <= dividend;
        div_b       <= divisor;
        div_by_zero <= (divisor == 32'd0);
        // Divide-by-zero needs no settle time, so it captures on the next edge.
        cnt         <= (divisor == 32'd0) ? 4'd0 : SETTLE_M1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // A result capture takes priority over a simultaneous bus write.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else if (capture) begin
      hi_out <= div_by_zero ? div_a : div_c[63:32];
      lo_out <= div_by_zero ? 32'hFFFF_FFFF : div_c[31:0];
    end else begin
      if (hi_ld) hi_out <= bus_in;
      if (lo_ld) lo_out <= bus_in;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed divides with a queued scoreboard checked on each done pulse.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        busy;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [64:0] div_c;
  logic        done;
  logic        div_by_zero;
  logic [31:0] bus_in;
  logic        hi_ld;
  logic        lo_ld;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  always #5 clock = ~clock;

  div_sequencer #(.SETTLE_CYCLES(4)) dut (
    .clock(clock), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .div_a(div_a), .div_b(div_b), .div_c(div_c),
    .done(done), .div_by_zero(div_by_zero), .bus_in(bus_in), .hi_ld(hi_ld),
    .lo_ld(lo_ld), .hi_out(hi_out), .lo_out(lo_out)
  );

  // Divider stand-in; bit 64 set and a junk pattern on /0 so misuse is visible.
  logic signed [31:0] sa, sb;
  always_comb begin
    sa = $signed(div_a);
    sb = $signed(div_b);
    if (div_b == 32'd0) div_c = {1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A};
    else                div_c = {1'b1, 32'(sa % sb), 32'(sa / sb)};
  end

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = exp_q.pop_front();
        check("done_hi", hi_out, e.hi);
        check("done_lo", lo_out, e.lo);
        check("done_dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  task automatic do_start(input logic [31:0] dvd, input logic [31:0] dvs, input bit push,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    if (push) exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done) return;
      if (busy) busy_cycles++;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected done within 50 cycles");
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  int n;
  int d0;
  int gap;

  initial begin
    clr = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    bus_in = '0; hi_ld = 1'b0; lo_ld = 1'b0;
    repeat (2) step();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    clr = 1'b1;
    step();

    // Basic divide 100/7
    do_start(32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    wait_done(n);
    check("basic_busy_cycles", n, 32'd4);
    check("ready_in_done_cycle", {31'd0, ready}, 32'd1);
    check("basic_div_a", div_a, 32'd100);
    check("basic_div_b", div_b, 32'd7);
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("hi_held", hi_out, 32'd2);

    // Divide by zero, then a normal divide clears the flag
    step();
    do_start(32'd55, 32'd0, 1, 32'd55, 32'hFFFF_FFFF, 1'b1);
    wait_done(n);
    check("dbz_busy_cycles", n, 32'd1);
    repeat (3) @(negedge clock);
    check("dbz_sticky", {31'd0, div_by_zero}, 32'd1);
    step();
    do_start(32'd9, 32'd3, 1, 32'd0, 32'd3, 1'b0);
    wait_done(n);
    check("after_dbz_busy_cycles", n, 32'd4);

    // Signed operands pass straight through: -100/7 -> q=-14, r=-2
    step();
    do_start(32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    wait_done(n);

    // Start while busy is ignored
    step();
    d0 = done_seen;
    do_start(32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    repeat (3) step();
    start = 1'b0;
    check("busy_div_a_stable", div_a, 32'd100);
    check("busy_div_b_stable", div_b, 32'd7);
    wait_done(n);
    repeat (10) @(negedge clock);
    check("single_done", done_seen - d0, 32'd1);

    // Reset mid-WAIT aborts the operation
    step();
    do_start(32'd100, 32'd7, 0, 32'd0, 32'd0, 1'b0);
    step();
    d0 = done_seen;
    clr = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi_out, 32'd0);
    check("abort_lo", lo_out, 32'd0);
    step();
    clr = 1'b1;
    repeat (10) @(negedge clock);
    check("abort_no_done", done_seen - d0, 32'd0);

    // Bus load colliding with capture loses; in IDLE it lands
    step();
    do_start(32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    repeat (3) step();
    hi_ld = 1'b1; bus_in = 32'hDEAD_BEEF;
    step();
    hi_ld = 1'b0;
    check("collision_hi", hi_out, 32'd2);
    step();
    hi_ld = 1'b1;
    step();
    hi_ld = 1'b0;
    check("idle_hi_ld", hi_out, 32'hDEAD_BEEF);
    check("idle_hi_ld_lo_kept", lo_out, 32'd14);
    lo_ld = 1'b1; bus_in = 32'h1234_5678;
    step();
    lo_ld = 1'b0;
    check("idle_lo_ld", lo_out, 32'h1234_5678);
    check("idle_lo_ld_hi_kept", hi_out, 32'hDEAD_BEEF);

    // Back-to-back: start issued in the done cycle
    step();
    do_start(32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    wait_done(n);
    do_start(32'd20, 32'd6, 1, 32'd2, 32'd3, 1'b0);
    gap = 1;
    while (gap < 50) begin
      @(negedge clock);
      if (done) break;
      gap++;
    end
    check("b2b_gap", gap, 32'd5);

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
